operand_stage: RTL and testbench
================================

Name: operand_stage

Overview:
- Next-generation ALU operand selector with an ID/EX pipeline register.
- Per operand, selects register, immediate, PC or zero, with priority-ordered forwarding from NUM_FWD downstream stages and load-use hazard stalling.
- Forwarded rs2 is also provided as store data.
- Sits between decode/register-file read and the EX stage; uses a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width of pc/reg/imm/forward/output data.
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest, highest priority.
- CNT_W, 16, width of saturating stall counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- pc  in  XLEN  instruction PC.
- rs1_addr, rs2_addr  in  5 each  source register indices.
- reg_data1, reg_data2  in  XLEN each  register-file read data.
- imm  in  XLEN  decoded immediate.
- aluop1_type, aluop2_type  in  2 each  0=REG, 1=IMM, 2=PC, 3=NONE.
- rs2_used  in  1  rs2 needed as store data independent of aluop2_type.
- fwd_valid  in  NUM_FWD  source i holds a register write.
- fwd_pending  in  NUM_FWD  source i result not yet available (load in flight).
- fwd_rd  in  NUM_FWD*5  destination index per source, source i at [5i+4:5i].
- fwd_data  in  NUM_FWD*XLEN  result per source, source i at [XLEN*i+XLEN-1:XLEN*i].
- flush  in  1  synchronous pipeline kill.
- out_valid  out  1  registered operands valid.
- out_ready  in  1  EX consumes.
- data1, data2  out  XLEN each  registered ALU operands.
- store_data  out  XLEN  registered forwarded rs2 value.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0, data1=data2=store_data=0, stall_count=0.
  - in_ready is combinational; it equals 0 only because of the terms below.
- Forward resolve for register index r:
  - r==0 → value 0, never forwarded, never a hazard.
  - Otherwise take the lowest index i with fwd_valid[i] && fwd_rd[i]==r → fwd_data[i].
  - If no source matches → regfile data.
  - Match on a pending source → hazard, even if an older source also matches.
- Operand select per channel:
  - REG → resolved rs value.
  - IMM → imm.
  - PC → pc.
  - NONE → 0.
- store_data is always the resolved rs2 value.
- Hazard:
  - in_valid && (rs1 pending match && aluop1_type==REG, or rs2 pending match && (aluop2_type==REG || rs2_used)).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready.
  - On accept, register data1/data2/store_data; out_valid=1 next cycle.
  - Latency is exactly 1 cycle.
- If out_valid && out_ready && !accept → out_valid=0.
- Back-to-back: accept with out_ready=1 while out_valid=1 replaces the held entry with no bubble.
- Backpressure: out_valid && !out_ready → registers hold, in_ready=0.
- Flush has highest priority:
  - out_valid=0 next cycle; no accept that cycle.
  - Data registers keep their previous values.
  - stall_count does not increment.
- stall_count:
  - +1 on each cycle with hazard && !flush.
  - Saturates at 2^CNT_W-1; never wraps.
- Reset mid-transfer drops the held entry immediately; out_valid=0 asynchronously.
- No combinational path from out_ready to data outputs.

Test Plan:
- Basic select: aluop1=PC, aluop2=IMM, pc=0x100, imm=0x7FF, in_valid=1, out_ready=1 → next cycle out_valid=1, data1=0x100, data2=0x7FF.
- Forward priority: rs1=5, fwd_valid=2'b11, fwd_rd={5,5}, fwd_data[0]=0xAAAA, fwd_data[1]=0xBBBB, aluop1=REG → data1=0xAAAA; with fwd_valid=2'b10 → data1=0xBBBB.
- x0 guard: rs1=0, fwd_valid[0]=1, fwd_rd[0]=0, fwd_data=0xDEAD, aluop1=REG → data1=0, no hazard.
- Load-use stall: rs2=7, rs2_used=1, aluop2=IMM, fwd_pending[0]=1, fwd_rd[0]=7 held 3 cycles, then pending=0 with fwd_data[0]=0x42 → in_ready=0 for 3 cycles, stall_count=3, then accept with store_data=0x42.
- Backpressure and flush: out_valid=1, out_ready=0 for 2 cycles → outputs stable, in_ready=0; then flush=1 → out_valid=0 next cycle, no accept, data unchanged.
- Saturation and reset: CNT_W=4 with a permanent hazard for 20 cycles → stall_count=15; rst_n pulsed low mid-cycle → out_valid=0 and stall_count=0 immediately.

Source files
------------

// File: rtl/operand_stage_if.sv
// Decode-to-EX operand bundle: upstream handshake, forwarding sources, registered operands.
// master = decode/EX side, slave = operand_stage.
interface operand_stage_if #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [XLEN-1:0]         pc;
  logic [4:0]              rs1_addr;
  logic [4:0]              rs2_addr;
  logic [XLEN-1:0]         reg_data1;
  logic [XLEN-1:0]         reg_data2;
  logic [XLEN-1:0]         imm;
  logic [1:0]              aluop1_type;
  logic [1:0]              aluop2_type;
  logic                    rs2_used;
  logic [NUM_FWD-1:0]      fwd_valid;
  logic [NUM_FWD-1:0]      fwd_pending;
  logic [NUM_FWD*5-1:0]    fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic                    flush;
  logic                    out_valid;
  logic                    out_ready;
  logic [XLEN-1:0]         data1;
  logic [XLEN-1:0]         data2;
  logic [XLEN-1:0]         store_data;
  logic [CNT_W-1:0]        stall_count;

  modport master (
    output in_valid, pc, rs1_addr, rs2_addr, reg_data1, reg_data2, imm,
           aluop1_type, aluop2_type, rs2_used, fwd_valid, fwd_pending,
           fwd_rd, fwd_data, flush, out_ready,
    input  in_ready, out_valid, data1, data2, store_data, stall_count
  );

  modport slave (
    input  in_valid, pc, rs1_addr, rs2_addr, reg_data1, reg_data2, imm,
           aluop1_type, aluop2_type, rs2_used, fwd_valid, fwd_pending,
           fwd_rd, fwd_data, flush, out_ready,
    output in_ready, out_valid, data1, data2, store_data, stall_count
  );
endinterface

// File: rtl/operand_stage.sv
// ALU operand select with priority forwarding and load-use stall into a 1-cycle ID/EX register.
// Backpressure: holds the entry while out_ready=0 and drops in_ready; flush kills the entry.
module operand_stage #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
) (
  input logic           clk,
  input logic           rst_n,
  operand_stage_if.slave bus
);

  localparam logic [1:0] OP_REG = 2'd0;
  localparam logic [1:0] OP_IMM = 2'd1;
  localparam logic [1:0] OP_PC  = 2'd2;

  // Youngest matching source wins; x0 is hardwired to zero.
  function automatic logic [XLEN-1:0] fwd_value(
    input logic [4:0]              r,
    input logic [XLEN-1:0]         rf,
    input logic [NUM_FWD-1:0]      fv,
    input logic [NUM_FWD*5-1:0]    fr,
    input logic [NUM_FWD*XLEN-1:0] fd
  );
    logic [XLEN-1:0] v;
    logic            hit;
    v   = rf;
    hit = 1'b0;
    if (r == 5'd0) begin
      v = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fv[i] && (fr[5*i +: 5] == r)) begin
          v   = fd[XLEN*i +: XLEN];
          hit = 1'b1;
        end
      end
    end
    return v;
  endfunction

  // Any matching in-flight load blocks the read, regardless of older matches.
  function automatic logic fwd_pend(
    input logic [4:0]           r,
    input logic [NUM_FWD-1:0]   fv,
    input logic [NUM_FWD-1:0]   fp,
    input logic [NUM_FWD*5-1:0] fr
  );
    logic p;
    p = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if ((r != 5'd0) && fv[i] && fp[i] && (fr[5*i +: 5] == r)) p = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [XLEN-1:0] op_mux(
    input logic [1:0]      t,
    input logic [XLEN-1:0] rv,
    input logic [XLEN-1:0] iv,
    input logic [XLEN-1:0] pv
  );
    logic [XLEN-1:0] v;
    case (t)
      OP_REG:  v = rv;
      OP_IMM:  v = iv;
      OP_PC:   v = pv;
      default: v = '0;
    endcase
    return v;
  endfunction

  logic [XLEN-1:0]  rs1_val, rs2_val;
  logic             rs1_pend, rs2_pend;
  logic             hazard, accept;
  logic             out_valid_q;
  logic [XLEN-1:0]  data1_q, data2_q, store_q;
  logic [CNT_W-1:0] stall_q;

  always_comb begin
    rs1_val  = fwd_value(bus.rs1_addr, bus.reg_data1, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    rs2_val  = fwd_value(bus.rs2_addr, bus.reg_data2, bus.fwd_valid, bus.fwd_rd, bus.fwd_data);
    rs1_pend = fwd_pend(bus.rs1_addr, bus.fwd_valid, bus.fwd_pending, bus.fwd_rd);
    rs2_pend = fwd_pend(bus.rs2_addr, bus.fwd_valid, bus.fwd_pending, bus.fwd_rd);
    hazard   = bus.in_valid &&
               ((rs1_pend && (bus.aluop1_type == OP_REG)) ||
                (rs2_pend && ((bus.aluop2_type == OP_REG) || bus.rs2_used)));
  end

  assign bus.in_ready = !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      store_q     <= '0;
      stall_q     <= '0;
    end else begin
      if (bus.flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        data1_q     <= op_mux(bus.aluop1_type, rs1_val, bus.imm, bus.pc);
        data2_q     <= op_mux(bus.aluop2_type, rs2_val, bus.imm, bus.pc);
        store_q     <= rs2_val;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (hazard && !bus.flush && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.data1       = data1_q;
  assign bus.data2       = data2_q;
  assign bus.store_data  = store_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Randomized and directed bench for operand_stage against a behavioural reference model.
module tb_operand_stage;
  localparam int XLEN    = 32;
  localparam int NUM_FWD = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  operand_stage_if #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) ifc ();

  operand_stage #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus fields
  bit          t_in_valid, t_rs2u, t_flush, t_out_ready;
  int          t_rs1, t_rs2, t_op1, t_op2;
  logic [31:0] t_pc, t_r1, t_r2, t_imm;
  bit          fv [NUM_FWD];
  bit          fp [NUM_FWD];
  int          frd [NUM_FWD];
  logic [31:0] fdat [NUM_FWD];

  // reference state
  bit          m_valid;
  logic [31:0] m_d1, m_d2, m_sd;
  int          m_cnt;
  bit          obs_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    t_in_valid = 0; t_rs2u = 0; t_flush = 0; t_out_ready = 1;
    t_rs1 = 0; t_rs2 = 0; t_op1 = 3; t_op2 = 3;
    t_pc = 0; t_r1 = 0; t_r2 = 0; t_imm = 0;
    for (int i = 0; i < NUM_FWD; i++) begin
      fv[i] = 0; fp[i] = 0; frd[i] = 0; fdat[i] = 0;
    end
  endtask

  task automatic apply_inputs();
    ifc.in_valid    = t_in_valid;
    ifc.pc          = t_pc;
    ifc.rs1_addr    = 5'(t_rs1);
    ifc.rs2_addr    = 5'(t_rs2);
    ifc.reg_data1   = t_r1;
    ifc.reg_data2   = t_r2;
    ifc.imm         = t_imm;
    ifc.aluop1_type = 2'(t_op1);
    ifc.aluop2_type = 2'(t_op2);
    ifc.rs2_used    = t_rs2u;
    ifc.flush       = t_flush;
    ifc.out_ready   = t_out_ready;
    for (int i = 0; i < NUM_FWD; i++) begin
      ifc.fwd_valid[i]           = fv[i];
      ifc.fwd_pending[i]         = fp[i];
      ifc.fwd_rd[5*i +: 5]       = 5'(frd[i]);
      ifc.fwd_data[XLEN*i +: XLEN] = fdat[i];
    end
  endtask

  // Register value seen by an instruction: oldest match first, younger overrides.
  function automatic logic [31:0] ref_resolve(input int r, input logic [31:0] rf, output bit pend);
    logic [31:0] v;
    pend = 0;
    v = rf;
    if (r == 0) return 32'd0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fv[i] && frd[i] == r) begin
        v = fdat[i];
        if (fp[i]) pend = 1;
      end
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_sel(input int t, input logic [31:0] rv);
    if (t == 0) return rv;
    if (t == 1) return t_imm;
    if (t == 2) return t_pc;
    return 32'd0;
  endfunction

  task automatic check_outputs();
    chk("out_valid",   ifc.out_valid,   m_valid);
    chk("data1",       ifc.data1,       m_d1);
    chk("data2",       ifc.data2,       m_d2);
    chk("store_data",  ifc.store_data,  m_sd);
    chk("stall_count", ifc.stall_count, m_cnt);
  endtask

  // Called one time unit after a rising edge; returns at the same phase of the next cycle.
  task automatic cycle();
    bit p1, p2, h, rdy, acc;
    logic [31:0] v1, v2;
    apply_inputs();
    #1;
    v1 = ref_resolve(t_rs1, t_r1, p1);
    v2 = ref_resolve(t_rs2, t_r2, p2);
    h  = t_in_valid && ((p1 && t_op1 == 0) || (p2 && (t_op2 == 0 || t_rs2u)));
    rdy = !t_flush && !h && (!m_valid || t_out_ready);
    obs_rdy = ifc.in_ready;
    chk("in_ready", ifc.in_ready, rdy);
    acc = t_in_valid && rdy;
    if (t_flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_d1 = ref_sel(t_op1, v1);
      m_d2 = ref_sel(t_op2, v2);
      m_sd = v2;
    end else if (m_valid && t_out_ready) m_valid = 0;
    if (h && !t_flush && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_valid = 0; m_d1 = 0; m_d2 = 0; m_sd = 0; m_cnt = 0;
  endtask

  task automatic full_reset();
    set_idle();
    apply_inputs();
    rst_n = 0;
    #3;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    t_in_valid  = ($urandom_range(0, 9) < 8);
    t_flush     = ($urandom_range(0, 11) == 0);
    t_out_ready = ($urandom_range(0, 9) < 7);
    t_rs2u      = $urandom_range(0, 1);
    t_rs1 = $urandom_range(0, 7);
    t_rs2 = $urandom_range(0, 7);
    t_op1 = $urandom_range(0, 3);
    t_op2 = $urandom_range(0, 3);
    t_pc = $urandom; t_r1 = $urandom; t_r2 = $urandom; t_imm = $urandom;
    for (int i = 0; i < NUM_FWD; i++) begin
      fv[i]   = $urandom_range(0, 1);
      fp[i]   = ($urandom_range(0, 5) == 0);
      frd[i]  = $urandom_range(0, 7);
      fdat[i] = $urandom;
    end
  endtask

  initial begin
    logic [31:0] h1, h2, hs;
    checks = 0;
    failures = 0;
    rst_n = 0;
    model_reset();
    full_reset();

    // basic select
    set_idle();
    t_in_valid = 1; t_op1 = 2; t_op2 = 1; t_pc = 32'h100; t_imm = 32'h7FF;
    cycle();
    chk("basic_vld", ifc.out_valid, 1);
    chk("basic_d1", ifc.data1, 32'h100);
    chk("basic_d2", ifc.data2, 32'h7FF);

    // forward priority
    set_idle();
    t_in_valid = 1; t_op1 = 0; t_rs1 = 5; t_r1 = 32'h1111;
    fv[0] = 1; fv[1] = 1; frd[0] = 5; frd[1] = 5; fdat[0] = 32'hAAAA; fdat[1] = 32'hBBBB;
    cycle();
    chk("fwd_young", ifc.data1, 32'hAAAA);
    fv[0] = 0;
    cycle();
    chk("fwd_old", ifc.data1, 32'hBBBB);

    // x0 guard
    set_idle();
    t_in_valid = 1; t_op1 = 0; t_rs1 = 0; t_r1 = 32'h5555;
    fv[0] = 1; fp[0] = 1; frd[0] = 0; fdat[0] = 32'hDEAD;
    cycle();
    chk("x0_rdy", obs_rdy, 1);
    chk("x0_d1", ifc.data1, 0);

    // load-use stall
    full_reset();
    set_idle();
    t_in_valid = 1; t_rs2 = 7; t_rs2u = 1; t_op2 = 1; t_imm = 32'h9;
    fv[0] = 1; fp[0] = 1; frd[0] = 7;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("lu_rdy", obs_rdy, 0);
    end
    chk("lu_cnt", ifc.stall_count, 3);
    fp[0] = 0; fdat[0] = 32'h42;
    cycle();
    chk("lu_rdy_go", obs_rdy, 1);
    chk("lu_store", ifc.store_data, 32'h42);

    // backpressure then flush
    set_idle();
    t_in_valid = 1; t_op1 = 1; t_op2 = 2; t_imm = 32'h1234; t_pc = 32'h5678;
    cycle();
    h1 = ifc.data1; h2 = ifc.data2; hs = ifc.store_data;
    t_out_ready = 0; t_imm = 32'hFFFF; t_pc = 32'hEEEE;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("bp_rdy", obs_rdy, 0);
      chk("bp_d1", ifc.data1, h1);
      chk("bp_d2", ifc.data2, h2);
    end
    t_flush = 1; t_out_ready = 1;
    cycle();
    chk("fl_vld", ifc.out_valid, 0);
    chk("fl_d1", ifc.data1, h1);
    chk("fl_sd", ifc.store_data, hs);

    // saturation
    set_idle();
    t_in_valid = 1; t_op1 = 0; t_rs1 = 3; fv[1] = 1; fp[1] = 1; frd[1] = 3;
    for (int k = 0; k < 20; k++) cycle();
    chk("sat_cnt", ifc.stall_count, CNT_MAX);

    // reset mid-cycle with a held entry
    set_idle();
    t_in_valid = 1; t_op1 = 1; t_imm = 32'hCAFE; t_out_ready = 0;
    cycle();
    set_idle();
    t_out_ready = 0;
    apply_inputs();
    #2;
    rst_n = 0;
    #1;
    chk("rst_vld", ifc.out_valid, 0);
    chk("rst_cnt", ifc.stall_count, 0);
    chk("rst_d1", ifc.data1, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    check_outputs();

    // random phase
    for (int k = 0; k < 600; k++) begin
      randomize_inputs();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
